// File: rtl/char_pixel_server_if.sv
// ---------------------------------------------------------------------------
// char_pixel_server_if
// Request/response bundle between the end-of-game overlay drawer (master)
// and the character-pixel server (slave).
//   char_yx     : {row[3:0], col[3:0]} of the requested character cell
//   char_line   : pixel line within the cell, 0..79
//   msg_sel     : 0 = "GAME OVER", 1 = "YOU WIN"
//   char_pixels : scaled 80-pixel glyph row, bit 79 = leftmost pixel
//   char_code   : stage-1 character code (debug/verification)
// ---------------------------------------------------------------------------
interface char_pixel_server_if;
    logic [7:0]  char_yx;
    logic [7:0]  char_line;
    logic        msg_sel;
    logic [79:0] char_pixels;
    logic [6:0]  char_code;

    modport master (
        output char_yx,
        output char_line,
        output msg_sel,
        input  char_pixels,
        input  char_code
    );

    modport slave (
        input  char_yx,
        input  char_line,
        input  msg_sel,
        output char_pixels,
        output char_code
    );
endinterface

// File: rtl/char_pixel_server.sv
// ---------------------------------------------------------------------------
// char_pixel_server
// Returns one 80-pixel row of an 8x16 glyph scaled to an 80x80 cell for the
// end-of-game overlay. A request is accepted every cycle and answered with a
// fixed two-cycle latency: stage 1 looks up the character code and font row,
// stage 2 fetches the glyph row, replicates each bit SCALE_X times and gates
// the result with a vsync-driven blink phase.
// Ports:
//   pclk     : pixel clock
//   rst      : asynchronous active-high reset
//   vsync_in : frame sync, rising edges drive the blink timebase
//   blink_en : 1 = blink the text, 0 = always visible
//   bus      : slave side of char_pixel_server_if (request in, pixels out)
// ---------------------------------------------------------------------------
module char_pixel_server #(
    parameter int          SCALE_X      = 10,
    parameter int          ROW_DIV      = 5,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [6:0]  BLANK_CODE   = 7'h20
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 vsync_in,
    input  logic                 blink_en,
    char_pixel_server_if.slave   bus
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // Message table indexed by {msg_sel, char_yx}; any row other than 0 or a
    // column past the end of the message falls through to the blank code.
    function automatic logic [6:0] msg_code(input logic [8:0] idx);
        case (idx)
            9'h000:  return 7'h47; // G
            9'h001:  return 7'h41; // A
            9'h002:  return 7'h4D; // M
            9'h003:  return 7'h45; // E
            9'h004:  return 7'h20; // space
            9'h005:  return 7'h4F; // O
            9'h006:  return 7'h56; // V
            9'h007:  return 7'h45; // E
            9'h008:  return 7'h52; // R
            9'h100:  return 7'h59; // Y
            9'h101:  return 7'h4F; // O
            9'h102:  return 7'h55; // U
            9'h103:  return 7'h20; // space
            9'h104:  return 7'h57; // W
            9'h105:  return 7'h49; // I
            9'h106:  return 7'h4E; // N
            default: return BLANK_CODE;
        endcase
    endfunction

    // Font glyphs, 16 rows of 8 bits, row 0 in the most significant byte.
    function automatic logic [127:0] font_glyph(input logic [6:0] code);
        case (code)
            7'h41:   return 128'h00001038_6CC6C6FE_C6C6C6C6_00000000; // A
            7'h45:   return 128'h0000FE66_62687868_606266FE_00000000; // E
            7'h47:   return 128'h00003C66_C2C0C0DE_C6C6663A_00000000; // G
            7'h49:   return 128'h00003C18_18181818_1818183C_00000000; // I
            7'h4D:   return 128'h0000C6EE_FEFED6C6_C6C6C6C6_00000000; // M
            7'h4E:   return 128'h0000C6E6_F6FEDECE_C6C6C6C6_00000000; // N
            7'h4F:   return 128'h00007CC6_C6C6C6C6_C6C6C67C_00000000; // O
            7'h52:   return 128'h0000FC66_66667C6C_666666E6_00000000; // R
            7'h55:   return 128'h0000C6C6_C6C6C6C6_C6C6C67C_00000000; // U
            7'h56:   return 128'h0000C6C6_C6C6C6C6_C66C3810_00000000; // V
            7'h57:   return 128'h0000C6C6_C6C6D6D6_D6FEEE6C_00000000; // W
            7'h59:   return 128'h00006666_66663C18_1818183C_00000000; // Y
            default: return 128'h0;                                    // 0x20 and unknown
        endcase
    endfunction

    function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [3:0] row);
        logic [127:0] g;
        g = font_glyph(code);
        return g[(4'd15 - row) * 8 +: 8];
    endfunction

    // Pixel i takes glyph bit i / SCALE_X, so bit 7 fills pixels 79..70.
    function automatic logic [79:0] scale_row(input logic [7:0] g);
        logic [79:0] px;
        px = '0;
        for (int i = 0; i < 80; i++) begin
            px[i] = g[i / SCALE_X];
        end
        return px;
    endfunction

    logic [7:0]       row_full;
    logic             vsync_prev;
    logic             vsync_rise;
    logic [CNT_W-1:0] blink_cnt;
    logic [CNT_W-1:0] blink_cnt_next;
    logic             blink_vis;
    logic             blink_vis_next;

    logic [6:0]       code_p1;
    logic [3:0]       row_p1;
    logic             vld_p1;
    logic [79:0]      pixels_p2;

    assign row_full   = bus.char_line / 8'(ROW_DIV);
    assign vsync_rise = vsync_in & ~vsync_prev;

    // Blink timebase. The stage-2 gate uses the next phase so a toggle edge
    // already applies to the output produced on that same edge.
    always_comb begin
        blink_cnt_next = blink_cnt;
        blink_vis_next = blink_vis;
        if (!blink_en) begin
            blink_cnt_next = '0;
            blink_vis_next = 1'b1;
        end else if (vsync_rise) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt_next = '0;
                blink_vis_next = ~blink_vis;
            end else begin
                blink_cnt_next = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_prev <= 1'b0;
            blink_cnt  <= '0;
            blink_vis  <= 1'b1;
        end else begin
            vsync_prev <= vsync_in;
            blink_cnt  <= blink_cnt_next;
            blink_vis  <= blink_vis_next;
        end
    end

    // Stage 1: character code, font row and line range check
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            code_p1 <= '0;
            row_p1  <= '0;
            vld_p1  <= 1'b0;
        end else begin
            code_p1 <= msg_code({bus.msg_sel, bus.char_yx});
            row_p1  <= row_full[3:0];
            vld_p1  <= (bus.char_line < 8'd80);
        end
    end

    // Stage 2: glyph fetch, horizontal scaling and output gating
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pixels_p2 <= '0;
        end else if (vld_p1 && blink_vis_next) begin
            pixels_p2 <= scale_row(glyph_row(code_p1, row_p1));
        end else begin
            pixels_p2 <= '0;
        end
    end

    assign bus.char_code   = code_p1;
    assign bus.char_pixels = pixels_p2;

endmodule

// File: tb/tb_char_pixel_server.sv
module tb_char_pixel_server;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    logic vsync_in = 1'b0;
    logic blink_en = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    char_pixel_server_if bus();

    char_pixel_server #(
        .SCALE_X(10), .ROW_DIV(5), .BLINK_FRAMES(2), .BLANK_CODE(7'h20)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .blink_en(blink_en), .bus(bus)
    );

    always #5 pclk = ~pclk;

    // Expected scaled row built straight from the slice formula.
    function automatic logic [79:0] scale8(input logic [7:0] g);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[79 - 10*k -: 10] = {10{g[7-k]}};
        return r;
    endfunction

    task automatic drive(input logic sel, input logic [7:0] yx, input logic [7:0] line);
        bus.msg_sel   = sel;
        bus.char_yx   = yx;
        bus.char_line = line;
    endtask

    task automatic vsync_pulse();
        @(posedge pclk); #1 vsync_in = 1'b1;
        @(posedge pclk); #1 vsync_in = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h00, 8'd35);
        #2;
        checks++; if (bus.char_pixels !== 80'h0) begin failures++; $display("FAIL reset_pix got=%h want=0", bus.char_pixels); end
        checks++; if (bus.char_code !== 7'h00) begin failures++; $display("FAIL reset_code got=%h want=00", bus.char_code); end
        @(posedge pclk); #1 rst = 1'b0;
        // stream 'G' row 7 so the output is non-zero before the mid-stream reset
        repeat (3) @(posedge pclk);
        #1;
        checks++; if (bus.char_pixels !== scale8(8'hDE)) begin failures++; $display("FAIL pre_rst_pix got=%h want=%h", bus.char_pixels, scale8(8'hDE)); end
        @(negedge pclk); rst = 1'b1;
        #1;
        checks++; if (bus.char_pixels !== 80'h0) begin failures++; $display("FAIL midrst_pix got=%h want=0", bus.char_pixels); end
        checks++; if (bus.char_code !== 7'h00) begin failures++; $display("FAIL midrst_code got=%h want=00", bus.char_code); end
        @(posedge pclk); #1;
        drive(1'b0, 8'h00, 8'd0);
        rst = 1'b0;
        @(posedge pclk); #1;
        checks++; if (bus.char_code !== 7'h47) begin failures++; $display("FAIL post_rst_code got=%h want=47", bus.char_code); end
        checks++; if (bus.char_pixels !== 80'h0) begin failures++; $display("FAIL post_rst_pix1 got=%h want=0", bus.char_pixels); end
        drive(1'b0, 8'h00, 8'd59);
        @(posedge pclk); #1;
        checks++; if (bus.char_pixels !== scale8(8'h00)) begin failures++; $display("FAIL post_rst_pix2 got=%h want=0", bus.char_pixels); end
        @(posedge pclk); #1;
        checks++; if (bus.char_pixels !== scale8(8'h3A)) begin failures++; $display("FAIL g_row11 got=%h want=%h", bus.char_pixels, scale8(8'h3A)); end
    endtask

    task automatic test_scaling();
        // 'I' (YOU WIN col 5), lines 15..19 all land on font row 3 = 8'b00011000
        for (int c = 0; c < 7; c++) begin
            @(posedge pclk); #1;
            if (c >= 2) begin
                checks++;
                if (bus.char_pixels !== 80'h0000_0003_FFFF_C000_0000) begin
                    failures++; $display("FAIL scale_I line%0d got=%h want=%h", 13 + c, bus.char_pixels, 80'h0000_0003_FFFF_C000_0000);
                end
            end
            if (c < 5) drive(1'b1, 8'h05, 8'(15 + c));
        end
        // line 20 moves to row 4, still 8'h18; line 60 is row 12, blank
        drive(1'b1, 8'h05, 8'd60);
        repeat (2) @(posedge pclk); #1;
        checks++; if (bus.char_pixels !== 80'h0) begin failures++; $display("FAIL scale_I_row12 got=%h want=0", bus.char_pixels); end
    endtask

    task automatic test_range();
        logic        sel_v [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0]  yx_v  [5] = '{8'h07, 8'h10, 8'h09, 8'hFF, 8'h00};
        logic [7:0]  ln_v  [5] = '{8'd35, 8'd35, 8'd35, 8'd35, 8'd80};
        logic [6:0]  ec    [5] = '{7'h20, 7'h20, 7'h20, 7'h20, 7'h47};
        for (int c = 0; c < 7; c++) begin
            @(posedge pclk); #1;
            if (c >= 2) begin
                checks++; if (bus.char_pixels !== 80'h0) begin failures++; $display("FAIL range_pix[%0d] got=%h want=0", c - 2, bus.char_pixels); end
            end
            if (c >= 1 && c <= 5) begin
                checks++; if (bus.char_code !== ec[c-1]) begin failures++; $display("FAIL range_code[%0d] got=%h want=%h", c - 1, bus.char_code, ec[c-1]); end
            end
            if (c < 5) drive(sel_v[c], yx_v[c], ln_v[c]);
        end
        drive(1'b0, 8'h00, 8'd79);
        @(posedge pclk); #1;
        checks++; if (dut.row_p1 !== 4'd15) begin failures++; $display("FAIL line79_row got=%0d want=15", dut.row_p1); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ec [9] = '{7'h47, 7'h41, 7'h4D, 7'h45, 7'h20, 7'h4F, 7'h56, 7'h45, 7'h52};
        logic [7:0] eg [9] = '{8'h3C, 8'h10, 8'hC6, 8'hFE, 8'h00, 8'h7C, 8'hC6, 8'hFE, 8'hFC};
        for (int c = 0; c < 11; c++) begin
            @(posedge pclk); #1;
            if (c >= 2) begin
                checks++;
                if (bus.char_pixels !== scale8(eg[c-2])) begin
                    failures++; $display("FAIL b2b_pix[%0d] got=%h want=%h", c - 2, bus.char_pixels, scale8(eg[c-2]));
                end
            end
            if (c >= 1 && c <= 9) begin
                checks++; if (bus.char_code !== ec[c-1]) begin failures++; $display("FAIL b2b_code[%0d] got=%h want=%h", c - 1, bus.char_code, ec[c-1]); end
            end
            if (c < 9) drive(1'b0, 8'(c), 8'd10);
        end
    endtask

    task automatic test_msg_switch();
        logic [6:0] ec [4] = '{7'h47, 7'h59, 7'h47, 7'h59};
        logic [7:0] eg [4] = '{8'hDE, 8'h18, 8'hDE, 8'h18};
        for (int c = 0; c < 6; c++) begin
            @(posedge pclk); #1;
            if (c >= 2) begin
                checks++;
                if (bus.char_pixels !== scale8(eg[c-2])) begin
                    failures++; $display("FAIL sw_pix[%0d] got=%h want=%h", c - 2, bus.char_pixels, scale8(eg[c-2]));
                end
            end
            if (c >= 1 && c <= 4) begin
                checks++; if (bus.char_code !== ec[c-1]) begin failures++; $display("FAIL sw_code[%0d] got=%h want=%h", c - 1, bus.char_code, ec[c-1]); end
            end
            if (c < 4) drive(c[0], 8'h00, 8'd35);
        end
    endtask

    task automatic test_blink();
        drive(1'b0, 8'h00, 8'd35);
        blink_en = 1'b1;
        repeat (3) @(posedge pclk); #1;
        vsync_pulse();
        checks++; if (dut.blink_cnt !== 1'b1) begin failures++; $display("FAIL blink_cnt1 got=%0d want=1", dut.blink_cnt); end
        checks++; if (bus.char_pixels !== scale8(8'hDE)) begin failures++; $display("FAIL blink_vis1 got=%h want=%h", bus.char_pixels, scale8(8'hDE)); end
        vsync_pulse();
        repeat (2) @(posedge pclk); #1;
        checks++; if (bus.char_pixels !== 80'h0) begin failures++; $display("FAIL blink_hidden got=%h want=0", bus.char_pixels); end
        vsync_pulse();
        vsync_pulse();
        repeat (2) @(posedge pclk); #1;
        checks++; if (bus.char_pixels !== scale8(8'hDE)) begin failures++; $display("FAIL blink_vis2 got=%h want=%h", bus.char_pixels, scale8(8'hDE)); end
        vsync_pulse();
        vsync_pulse();
        repeat (2) @(posedge pclk); #1;
        checks++; if (bus.char_pixels !== 80'h0) begin failures++; $display("FAIL blink_hidden2 got=%h want=0", bus.char_pixels); end
        blink_en = 1'b0;
        vsync_pulse();
        repeat (2) @(posedge pclk); #1;
        checks++; if (bus.char_pixels !== scale8(8'hDE)) begin failures++; $display("FAIL blink_off_vis got=%h want=%h", bus.char_pixels, scale8(8'hDE)); end
        checks++; if (dut.blink_cnt !== 1'b0) begin failures++; $display("FAIL blink_off_cnt got=%0d want=0", dut.blink_cnt); end
    endtask

    initial begin
        drive(1'b0, 8'h00, 8'd0);
        test_reset();
        test_scaling();
        test_range();
        test_back_to_back();
        test_msg_switch();
        test_blink();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
